uart_rx_fifo: RTL

Reader-side companion to uart_rx. Drains each received character via the charreceived/rd handshake, stores it in a synchronous FIFO with a host pop interface, and frees uart_rx for the next frame before it can overrun. Sits between uart_rx and the host/core logic; uart_rx may run on a divided peripheral clock, so the handshake inputs are resynchronised.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive-side FSM states and the bit
// positions of the {frame, parity} error flags.
package uart_pkg;

    localparam int UART_DATA_W = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } rx_state_t;

    localparam int ERR_FRAME_BIT  = 1;
    localparam int ERR_PARITY_BIT = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head is forced to zero while
// empty so the read port has a defined value without resetting storage.
module sync_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop frees the slot the same push needs, so a full FIFO still accepts it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains uart_rx through its charreceived/rd handshake into a host-side FIFO.
// Define UART_RX_FIFO_ERRFLAG_EN to store frame/parity flags with each entry.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_charreceived,
    input  logic                  rx_frameerror,
    input  logic                  rx_parityerror,
    output logic                  rx_rd,
    output logic [WIDTH-1:0]      data_out,
    output logic [1:0]            data_err,
    input  logic                  rd,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  clr_ovr
);

`ifdef UART_RX_FIFO_ERRFLAG_EN
    localparam int ENTRY_W = WIDTH + 2;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    rx_state_t          state;
    rx_state_t          next_state;
    logic               cs1;
    logic               cs2;
    logic               ack_hold;
    logic               cap_push;
    logic               drop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // charreceived comes from a possibly divided clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs1 <= 1'b0;
            cs2 <= 1'b0;
        end else begin
            cs1 <= rx_charreceived;
            cs2 <= cs1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ack_hold <= 1'b0;
        end else begin
            state    <= next_state;
            ack_hold <= (state == ACK);
        end
    end

    // ack_hold keeps rd up for at least two cycles even if cs2 fell early.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs2) next_state = CAPTURE;
            CAPTURE: next_state = ACK;
            ACK:     if (ack_hold && !cs2) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cap_push = 1'b0;
        rx_rd    = 1'b0;
        case (state)
            CAPTURE: cap_push = 1'b1;
            ACK:     rx_rd    = 1'b1;
            default: ;
        endcase
    end

    // A character is lost only when full and the host is not popping this cycle.
    assign drop = cap_push && full && !rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_ERRFLAG_EN
    always_comb begin
        push_entry                         = {2'b00, rx_data};
        push_entry[WIDTH + ERR_FRAME_BIT]  = rx_frameerror;
        push_entry[WIDTH + ERR_PARITY_BIT] = rx_parityerror;
    end

    assign data_out = head_entry[WIDTH-1:0];
    assign data_err = head_entry[WIDTH+1:WIDTH];
`else
    logic unused_err;

    assign unused_err = rx_frameerror ^ rx_parityerror;
    assign push_entry = rx_data;
    assign data_out   = head_entry;
    assign data_err   = 2'b00;
`endif

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_push),
        .push_data (push_entry),
        .pop       (rd),
        .pop_data  (head_entry),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

endmodule
